// File: rtl/icache_tag_array_if.sv
// icache_tag_array_if
//   Request/response bundle between the icache controller (master) and the
//   tag/valid array (slave). Signal suffixes are as seen from the array.
//   rd_*      : lookup request (set index + tag to compare)
//   wr_*      : tag/valid write to any subset of ways at one set
//   flush_i   : invalidate every set in every way
//   ready_o   : array accepts rd/wr this cycle
//   rd_valid_o, tag_way_o, vbit_o, hit_o, hit_way_o, multi_hit_o : lookup result
interface icache_tag_array_if #(
  parameter int N_WAY      = 4,
  parameter int TAG_WIDTH  = 20,
  parameter int ADDR_WIDTH = 8
);
  logic                         rd_req_i;
  logic [ADDR_WIDTH-1:0]        rd_addr_i;
  logic [TAG_WIDTH-1:0]         rd_tag_i;
  logic                         wr_req_i;
  logic [N_WAY-1:0]             wr_way_i;
  logic [ADDR_WIDTH-1:0]        wr_addr_i;
  logic [TAG_WIDTH-1:0]         wr_tag_i;
  logic                         wr_vbit_i;
  logic                         flush_i;
  logic                         ready_o;
  logic                         rd_valid_o;
  logic [N_WAY*TAG_WIDTH-1:0]   tag_way_o;
  logic [N_WAY-1:0]             vbit_o;
  logic                         hit_o;
  logic [N_WAY-1:0]             hit_way_o;
  logic                         multi_hit_o;

  modport master (
    output rd_req_i, rd_addr_i, rd_tag_i,
    output wr_req_i, wr_way_i, wr_addr_i, wr_tag_i, wr_vbit_i,
    output flush_i,
    input  ready_o, rd_valid_o, tag_way_o, vbit_o, hit_o, hit_way_o, multi_hit_o
  );

  modport slave (
    input  rd_req_i, rd_addr_i, rd_tag_i,
    input  wr_req_i, wr_way_i, wr_addr_i, wr_tag_i, wr_vbit_i,
    input  flush_i,
    output ready_o, rd_valid_o, tag_way_o, vbit_o, hit_o, hit_way_o, multi_hit_o
  );
endinterface

// File: rtl/icache_tag_array.sv
// icache_tag_array
//   N-way instruction-cache tag/valid array with a registered lookup and a
//   per-way tag compare. After reset and on flush a walk clears the valid
//   bits of every set, one set per cycle, while ready_o is held low.
//   Ports:
//     clk_i  : clock
//     rstn_i : asynchronous active-low reset
//     bus    : icache_tag_array_if.slave (request, write, flush, lookup result)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   INIT   | post-reset walk: clear valid bits of set cnt, all ways
//   IDLE   | accept lookups/writes; flush_i starts a FLUSH walk
//   FLUSH  | flush walk: same as INIT, entered from IDLE on flush_i
module icache_tag_array #(
  parameter int N_WAY      = 4,
  parameter int TAG_WIDTH  = 20,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input logic                clk_i,
  input logic                rstn_i,
  icache_tag_array_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       cnt_q, cnt_d;
  logic                        walk_clr;
  logic                        rd_acc;
  logic                        wr_acc;

  logic                        rd_valid_q;
  logic [N_WAY*TAG_WIDTH-1:0]  tag_way_q;
  logic [N_WAY-1:0]            vbit_q;
  logic [TAG_WIDTH-1:0]        rd_tag_q;
  logic [N_WAY-1:0]            hit_way;

  // Tag and valid storage: no reset, valid bits are cleared by the walk.
  logic [TAG_WIDTH-1:0]        tag_mem  [N_WAY][DEPTH];
  logic                        vbit_mem [N_WAY][DEPTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    walk_clr = 1'b0;
    rd_acc   = 1'b0;
    wr_acc   = 1'b0;
    case (state_q)
      ST_INIT, ST_FLUSH: begin
        // flush_i is ignored here: a walk in progress always runs to the end
        walk_clr = 1'b1;
        cnt_d    = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (bus.flush_i) begin
          // flush wins over any request in the same cycle
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else begin
          rd_acc = bus.rd_req_i;
          wr_acc = bus.wr_req_i;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      tag_way_q  <= '0;
      vbit_q     <= '0;
      rd_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        // read-first: samples contents before a same-cycle write lands
        for (int w = 0; w < N_WAY; w++) begin
          tag_way_q[w*TAG_WIDTH +: TAG_WIDTH] <= tag_mem[w][bus.rd_addr_i];
          vbit_q[w]                           <= vbit_mem[w][bus.rd_addr_i];
        end
        rd_tag_q <= bus.rd_tag_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < N_WAY; w++) begin
      if (walk_clr) begin
        vbit_mem[w][cnt_q] <= 1'b0;
      end else if (wr_acc && bus.wr_way_i[w]) begin
        tag_mem[w][bus.wr_addr_i]  <= bus.wr_tag_i;
        vbit_mem[w][bus.wr_addr_i] <= bus.wr_vbit_i;
      end
    end
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < N_WAY; w++) begin
      hit_way[w] = rd_valid_q & vbit_q[w] &
                   (tag_way_q[w*TAG_WIDTH +: TAG_WIDTH] == rd_tag_q);
    end
  end

  assign bus.ready_o     = (state_q == ST_IDLE);
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.tag_way_o   = tag_way_q;
  assign bus.vbit_o      = vbit_q;
  assign bus.hit_way_o   = hit_way;
  assign bus.hit_o       = |hit_way;
  // clearing the lowest set bit leaves something only if two or more were set
  assign bus.multi_hit_o = |(hit_way & (hit_way - N_WAY'(1)));

endmodule

// File: tb/tb_icache_tag_array.sv
// tb_icache_tag_array
//   Two array instances (4-way/20-bit/256-set and 2-way/24-bit/64-set)
//   checked every cycle against a behavioural model, plus directed literal
//   checks of the key scenarios.
module tb_icache_tag_array;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // per-instance drives (max widths, masked per instance)
  bit          d_rd    [2];
  bit          d_wr    [2];
  bit          d_flush [2];
  bit          d_vbit  [2];
  logic [7:0]  d_raddr [2];
  logic [7:0]  d_waddr [2];
  logic [23:0] d_rtag  [2];
  logic [23:0] d_wtag  [2];
  logic [3:0]  d_way   [2];

  // per-instance observed outputs
  logic        o_ready [2];
  logic        o_valid [2];
  logic [23:0] o_tag   [2][4];
  logic [3:0]  o_vb    [2];
  logic        o_hit   [2];
  logic [3:0]  o_hw    [2];
  logic        o_mh    [2];

  icache_tag_array_if #(.N_WAY(4), .TAG_WIDTH(20), .ADDR_WIDTH(8)) bus0 ();
  icache_tag_array_if #(.N_WAY(2), .TAG_WIDTH(24), .ADDR_WIDTH(6)) bus1 ();

  assign bus0.rd_req_i  = d_rd[0];
  assign bus0.rd_addr_i = d_raddr[0];
  assign bus0.rd_tag_i  = d_rtag[0][19:0];
  assign bus0.wr_req_i  = d_wr[0];
  assign bus0.wr_way_i  = d_way[0];
  assign bus0.wr_addr_i = d_waddr[0];
  assign bus0.wr_tag_i  = d_wtag[0][19:0];
  assign bus0.wr_vbit_i = d_vbit[0];
  assign bus0.flush_i   = d_flush[0];

  assign bus1.rd_req_i  = d_rd[1];
  assign bus1.rd_addr_i = d_raddr[1][5:0];
  assign bus1.rd_tag_i  = d_rtag[1];
  assign bus1.wr_req_i  = d_wr[1];
  assign bus1.wr_way_i  = d_way[1][1:0];
  assign bus1.wr_addr_i = d_waddr[1][5:0];
  assign bus1.wr_tag_i  = d_wtag[1];
  assign bus1.wr_vbit_i = d_vbit[1];
  assign bus1.flush_i   = d_flush[1];

  icache_tag_array #(.N_WAY(4), .TAG_WIDTH(20), .DEPTH(256), .ADDR_WIDTH(8)) u_dut0 (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus0)
  );

  icache_tag_array #(.N_WAY(2), .TAG_WIDTH(24), .DEPTH(64), .ADDR_WIDTH(6)) u_dut1 (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus1)
  );

  assign o_ready[0] = bus0.ready_o;
  assign o_valid[0] = bus0.rd_valid_o;
  assign o_vb[0]    = bus0.vbit_o;
  assign o_hit[0]   = bus0.hit_o;
  assign o_hw[0]    = bus0.hit_way_o;
  assign o_mh[0]    = bus0.multi_hit_o;
  assign o_ready[1] = bus1.ready_o;
  assign o_valid[1] = bus1.rd_valid_o;
  assign o_vb[1]    = {2'b00, bus1.vbit_o};
  assign o_hit[1]   = bus1.hit_o;
  assign o_hw[1]    = {2'b00, bus1.hit_way_o};
  assign o_mh[1]    = bus1.multi_hit_o;

  for (genvar i = 0; i < 4; i++) begin : g_tag0
    assign o_tag[0][i] = {4'h0, bus0.tag_way_o[i*20 +: 20]};
  end
  for (genvar i = 0; i < 2; i++) begin : g_tag1
    assign o_tag[1][i] = bus1.tag_way_o[i*24 +: 24];
  end
  assign o_tag[1][2] = '0;
  assign o_tag[1][3] = '0;

  function automatic int nw(int k);
    return (k == 0) ? 4 : 2;
  endfunction
  function automatic int dp(int k);
    return (k == 0) ? 256 : 64;
  endfunction
  function automatic logic [23:0] tmask(int k, logic [23:0] t);
    return (k == 0) ? (t & 24'h0FFFFF) : t;
  endfunction

  // ---------------- behavioural model ----------------
  logic [23:0] m_tag [2][4][256];
  bit          m_vb  [2][4][256];
  bit          m_kn  [2][4][256];
  int          walk_left [2];
  bit          e_valid [2];
  logic [23:0] e_tag [2][4];
  bit          e_vb  [2][4];
  bit          e_kn  [2][4];
  logic [23:0] e_rtag [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      walk_left[k] = dp(k);
      e_valid[k]   = 1'b0;
      e_rtag[k]    = '0;
      for (int w = 0; w < 4; w++) begin
        e_tag[k][w] = '0;
        e_vb[k][w]  = 1'b0;
        e_kn[k][w]  = 1'b1;
      end
    end
  endtask

  task automatic model_step(int k);
    int ra, wa;
    if (walk_left[k] > 0) begin
      for (int w = 0; w < nw(k); w++) m_vb[k][w][dp(k) - walk_left[k]] = 1'b0;
      walk_left[k] = walk_left[k] - 1;
      e_valid[k]   = 1'b0;
    end else if (d_flush[k]) begin
      walk_left[k] = dp(k);
      e_valid[k]   = 1'b0;
    end else begin
      e_valid[k] = d_rd[k];
      if (d_rd[k]) begin
        ra = int'(d_raddr[k]) % dp(k);
        for (int w = 0; w < nw(k); w++) begin
          e_tag[k][w] = m_tag[k][w][ra];
          e_vb[k][w]  = m_vb[k][w][ra];
          e_kn[k][w]  = m_kn[k][w][ra];
        end
        e_rtag[k] = tmask(k, d_rtag[k]);
      end
      if (d_wr[k]) begin
        wa = int'(d_waddr[k]) % dp(k);
        for (int w = 0; w < nw(k); w++) begin
          if (d_way[k][w]) begin
            m_tag[k][w][wa] = tmask(k, d_wtag[k]);
            m_vb[k][w][wa]  = d_vbit[k];
            m_kn[k][w][wa]  = 1'b1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rstn) begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [3:0] ehw;
      ehw = '0;
      for (int w = 0; w < nw(k); w++) begin
        if (e_valid[k] && e_vb[k][w] && e_kn[k][w] && e_tag[k][w] == e_rtag[k]) ehw[w] = 1'b1;
        chk($sformatf("m%0d vbit[%0d]", k, w), 32'(o_vb[k][w]), 32'(e_vb[k][w]));
        if (e_kn[k][w]) chk($sformatf("m%0d tag[%0d]", k, w), 32'(o_tag[k][w]), 32'(e_tag[k][w]));
      end
      chk($sformatf("m%0d ready", k), 32'(o_ready[k]), 32'(walk_left[k] == 0));
      chk($sformatf("m%0d rd_valid", k), 32'(o_valid[k]), 32'(e_valid[k]));
      chk($sformatf("m%0d hit_way", k), 32'(o_hw[k]), 32'(ehw));
      chk($sformatf("m%0d hit", k), 32'(o_hit[k]), 32'(ehw != 0));
      chk($sformatf("m%0d multi_hit", k), 32'(o_mh[k]), 32'($countones(ehw) > 1));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      d_rd[k] = 0; d_wr[k] = 0; d_flush[k] = 0; d_vbit[k] = 0;
      d_raddr[k] = '0; d_waddr[k] = '0; d_rtag[k] = '0; d_wtag[k] = '0; d_way[k] = '0;
    end
  endtask

  task automatic do_wr(int k, logic [3:0] way, logic [7:0] a, logic [23:0] t, bit v);
    d_wr[k] = 1; d_way[k] = way; d_waddr[k] = a; d_wtag[k] = t; d_vbit[k] = v;
    step();
    d_wr[k] = 0;
  endtask

  task automatic do_rd(int k, logic [7:0] a, logic [23:0] t);
    d_rd[k] = 1; d_raddr[k] = a; d_rtag[k] = t;
    step();
    d_rd[k] = 0;
  endtask

  task automatic reset_and_count(string nm);
    int c0, c1;
    rstn = 1'b0;
    model_reset();
    repeat (3) step();
    rstn = 1'b1;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 400 && !(o_ready[0] && o_ready[1]); i++) begin
      if (!o_ready[0]) c0++;
      if (!o_ready[1]) c1++;
      step();
    end
    chk({nm, " init cycles inst0"}, 32'(c0), 32'd256);
    chk({nm, " init cycles inst1"}, 32'(c1), 32'd64);
  endtask

  function automatic logic [23:0] pool(int k, int i);
    logic [23:0] t;
    case (i)
      0:       t = 24'h000055;
      1:       t = 24'hABCDEF;
      2:       t = 24'h123456;
      default: t = 24'h0F0F0F;
    endcase
    return tmask(k, t);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt;
    idle_all();
    model_reset();
    #1;
    reset_and_count("rst1");

    // empty array after init
    do_rd(0, 8'h00, 24'h0);
    chk("set00 vbit", 32'(o_vb[0]), 32'h0);
    chk("set00 hit", 32'(o_hit[0]), 32'h0);
    do_rd(0, 8'hFF, 24'h0);
    chk("setFF vbit", 32'(o_vb[0]), 32'h0);
    chk("setFF valid", 32'(o_valid[0]), 32'h1);

    // single-way hit and miss
    do_wr(0, 4'b0100, 8'h12, 24'hABCDE, 1'b1);
    do_rd(0, 8'h12, 24'hABCDE);
    chk("hit valid", 32'(o_valid[0]), 32'h1);
    chk("hit hit", 32'(o_hit[0]), 32'h1);
    chk("hit way", 32'(o_hw[0]), 32'h4);
    chk("hit multi", 32'(o_mh[0]), 32'h0);
    do_rd(0, 8'h12, 24'hABCDF);
    chk("miss hit", 32'(o_hit[0]), 32'h0);
    chk("miss vbit", 32'(o_vb[0]), 32'h4);
    step();
    chk("valid pulse", 32'(o_valid[0]), 32'h0);

    // multi-hit
    do_wr(0, 4'b0011, 8'h40, 24'h00055, 1'b1);
    do_rd(0, 8'h40, 24'h00055);
    chk("multi hit_way", 32'(o_hw[0]), 32'h3);
    chk("multi flag", 32'(o_mh[0]), 32'h1);

    // read-first on same-cycle write
    d_wr[0] = 1; d_way[0] = 4'b0001; d_waddr[0] = 8'h07; d_wtag[0] = 24'h11111; d_vbit[0] = 1;
    d_rd[0] = 1; d_raddr[0] = 8'h07; d_rtag[0] = 24'h11111;
    step();
    d_wr[0] = 0;
    chk("rfirst vbit", 32'(o_vb[0]), 32'h0);
    chk("rfirst hit", 32'(o_hit[0]), 32'h0);
    step();
    d_rd[0] = 0;
    chk("after wr vbit", 32'(o_vb[0]), 32'h1);
    chk("after wr hit_way", 32'(o_hw[0]), 32'h1);

    // second geometry
    do_wr(1, 4'b0010, 8'h12, 24'hABCDEF, 1'b1);
    do_rd(1, 8'h12, 24'hABCDEF);
    chk("i1 hit_way", 32'(o_hw[1]), 32'h2);
    chk("i1 multi", 32'(o_mh[1]), 32'h0);
    do_rd(1, 8'h12, 24'hABCDEE);
    chk("i1 miss hit", 32'(o_hit[1]), 32'h0);
    chk("i1 miss vbit", 32'(o_vb[1]), 32'h2);
    do_wr(1, 4'b0011, 8'h3F, 24'h000055, 1'b1);
    do_rd(1, 8'h3F, 24'h000055);
    chk("i1 multi hit_way", 32'(o_hw[1]), 32'h3);
    chk("i1 multi flag", 32'(o_mh[1]), 32'h1);

    // flush beats a same-cycle lookup; requests during the walk are dropped
    d_flush[0] = 1; d_rd[0] = 1; d_raddr[0] = 8'h12; d_rtag[0] = 24'hABCDE;
    step();
    d_flush[0] = 0;
    chk("flush drops rd", 32'(o_valid[0]), 32'h0);
    lowcnt = 0;
    while (o_ready[0] === 1'b0 && lowcnt < 400) begin
      lowcnt++;
      d_rd[0] = 1; d_raddr[0] = 8'h12;
      d_wr[0] = 1; d_way[0] = 4'b0100; d_waddr[0] = 8'h12; d_wtag[0] = 24'h12345; d_vbit[0] = 1;
      d_flush[0] = (lowcnt == 50);
      step();
    end
    idle_all();
    chk("flush cycles", 32'(lowcnt), 32'd256);
    do_rd(0, 8'h12, 24'hABCDE);
    chk("post flush vbit", 32'(o_vb[0]), 32'h0);
    chk("post flush hit", 32'(o_hit[0]), 32'h0);
    chk("post flush tag way2", 32'(o_tag[0][2]), 32'hABCDE);

    // reset in the middle of a walk
    d_flush[0] = 1;
    step();
    d_flush[0] = 0;
    repeat (100) step();
    rstn = 1'b0;
    model_reset();
    #1;
    chk("midrst ready", 32'(o_ready[0]), 32'h0);
    chk("midrst tag way2", 32'(o_tag[0][2]), 32'h0);
    chk("midrst vbit", 32'(o_vb[0]), 32'h0);
    reset_and_count("rst2");

    // randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        d_rd[k]    = bit'($urandom_range(0, 1));
        d_wr[k]    = bit'($urandom_range(0, 1));
        d_flush[k] = ($urandom_range(0, 399) == 0);
        d_raddr[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
        d_waddr[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
        d_rtag[k]  = pool(k, $urandom_range(0, 3));
        d_wtag[k]  = pool(k, $urandom_range(0, 2));
        d_way[k]   = 4'($urandom) & ((k == 0) ? 4'hF : 4'h3);
        d_vbit[k]  = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    idle_all();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/icache_tag_array.md
Name: icache_tag_array

Overview:
Parametrised N-way instruction-cache tag/valid array; successor to the fixed 4-way, 20-bit, 256-set tag memory. Adds a registered lookup with per-way tag compare (hit, one-hot hit way, multi-hit error) and a multi-cycle walk that clears valid bits after reset and on flush. Valid bits are held in SRAM-style storage alongside tags, not in per-bit flops. Sits between the icache controller and the data array.

Parameters:
N_WAY, 4, number of ways (>=1)
TAG_WIDTH, 20, tag bits per way
DEPTH, 256, sets per way (power of two, >=2)
ADDR_WIDTH, 8, set-index width; must equal log2(DEPTH)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
rd_req_i  in  1  lookup request
rd_addr_i  in  ADDR_WIDTH  lookup set index
rd_tag_i  in  TAG_WIDTH  tag to compare
wr_req_i  in  1  write request
wr_way_i  in  N_WAY  way enables (any subset)
wr_addr_i  in  ADDR_WIDTH  write set index
wr_tag_i  in  TAG_WIDTH  tag to write
wr_vbit_i  in  1  valid bit to write
flush_i  in  1  invalidate all sets, all ways
ready_o  out  1  array accepts rd/wr
rd_valid_o  out  1  lookup result valid
tag_way_o  out  N_WAY*TAG_WIDTH  tags of looked-up set; way i at [i*TAG_WIDTH +: TAG_WIDTH]
vbit_o  out  N_WAY  valid bits of looked-up set
hit_o  out  1  some way valid and tag equal
hit_way_o  out  N_WAY  one-hot (normally) hit vector
multi_hit_o  out  1  more than one way hit (error)

Behaviour:
- FSM states: INIT, IDLE, FLUSH. Walk counter cnt, ADDR_WIDTH bits.
- Reset (async assert): state=INIT, cnt=0, ready_o=0, rd_valid_o=0, tag_way_o=0, vbit_o=0, hit_o=0, hit_way_o=0, multi_hit_o=0. Tag contents are not reset.
- INIT/FLUSH: each cycle write vbit=0 to all ways at set cnt (tags untouched); cnt+=1. The cycle cnt==DEPTH-1 is written -> next state IDLE, cnt=0. Walk takes exactly DEPTH cycles. ready_o=0 throughout.
- IDLE: ready_o=1. flush_i=1 -> FLUSH next cycle, cnt=0. That cycle's rd_req_i/wr_req_i are dropped: flush wins.
- rd_req_i/wr_req_i while ready_o=0: dropped silently, no state change, rd_valid_o=0 next cycle.
- flush_i during INIT/FLUSH: ignored; walk continues, no restart.
- Reset asserted mid-walk: immediate return to INIT, cnt=0.
- Write (IDLE, wr_req_i=1, no flush): for each way i with wr_way_i[i]=1, tag[i][wr_addr_i]=wr_tag_i and vbit[i][wr_addr_i]=wr_vbit_i. wr_way_i=0 is a no-op.
- Lookup (IDLE, rd_req_i=1, no flush): latency 1. Next cycle rd_valid_o=1, tag_way_o/vbit_o carry set rd_addr_i, and rd_tag_i is registered.
- Compare: hit_way_o[i] = rd_valid_o & vbit_o[i] & (tag_way_o way i == registered tag). hit_o = OR of hit_way_o. multi_hit_o = more than one bit set. All three are combinational from registered values and are 0 when rd_valid_o=0.
- tag_way_o/vbit_o hold the last lookup until the next accepted lookup. rd_valid_o is a single-cycle pulse per accepted lookup.
- Read and write to the same set in the same cycle: read-first; the lookup returns pre-write contents.
- Back-to-back lookups: one per cycle, full throughput.

Test Plan:
- Reset release -> ready_o=0 for exactly 256 cycles, then 1. Lookup of set 0x00 and set 0xFF -> vbit_o=4'b0000, hit_o=0.
- Write way 2, addr 0x12, tag 0xABCDE, vbit 1. Lookup 0x12 with tag 0xABCDE -> next cycle rd_valid_o=1, hit_o=1, hit_way_o=4'b0100, multi_hit_o=0. Same lookup with tag 0xABCDF -> hit_o=0, vbit_o=4'b0100.
- Write wr_way_i=4'b0011 at 0x40, tag 0x00055 -> lookup tag 0x00055 gives hit_way_o=4'b0011, multi_hit_o=1.
- Same cycle: write way 0 at 0x07 (tag 0x11111, v=1) and lookup 0x07 -> returns old vbit_o[0]=0. Lookup next cycle -> vbit_o[0]=1, hit on tag 0x11111.
- flush_i with simultaneous rd_req_i in IDLE -> rd_valid_o stays 0, ready_o=0 for 256 cycles. Requests during the walk are dropped. Afterwards all vbit_o=0 and tags remain readable unchanged.
- Reset asserted at walk cycle 100 -> outputs cleared immediately; after release, full 256-cycle INIT again. Repeat with N_WAY=2, TAG_WIDTH=24, DEPTH=64 -> 64-cycle walk, hit/miss checks as above.
